adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable SPI slave that emulates the 8-channel, 12-bit serial ADC read by the pedal's ADC SPI master.
- Decodes the 3-bit channel address shifted in on DIN and returns 12-bit samples on DOUT using the same 16-clock frame.
- Enables on-board loopback (master pins wired to this block) and test-pattern injection without the real ADC fitted.
- Sits beside Top; samples come from a parallel source such as a counter, LUT or DDS.

Parameters:
- DATA_W, 12, sample width returned per frame.
- ADDR_W, 3, channel address width (8 channels).
- FRAME_BITS, 16, SCLK cycles per frame.
- LEAD_ZEROS, 4, zero bits driven before the sample MSB (FRAME_BITS - DATA_W).
- SYNC_STAGES, 2, flops in each input synchronizer.

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset_n  input  1  asynchronous active-low reset.
- cs_b  input  1  chip select from master, active low, asynchronous to clk.
- sclk  input  1  serial clock from master, asynchronous to clk.
- din  input  1  master-to-slave data, sampled on SCLK rising edges.
- dout  output  1  slave-to-master data, updated on SCLK falling edges.
- dout_oe  output  1  high while a frame is selected; board logic uses it for tristate/bus sharing.
- req_ch  output  ADDR_W  channel whose sample the next or current frame returns.
- sample_data  input  DATA_W  sample for req_ch; must be valid within 1 clk of any req_ch change.
- frame_done  output  1  1-clk pulse when 16 SCLK rising edges complete.
- frame_abort  output  1  1-clk pulse when cs_b rises mid-frame.
- addr_rx  output  ADDR_W  address decoded in the last completed frame.

Behaviour:
- Input conditioning
  - cs_b, sclk and din each pass through a SYNC_STAGES synchronizer, then edge detection on the synced versions.
  - All logic runs on clk; there are no SCLK-clocked flops.
- Reset values
  - dout=0, dout_oe=0, req_ch=0, addr_rx=0, frame_done=0, frame_abort=0.
  - bit_cnt=0, shift register=0, state=IDLE.
- State machine (IDLE, LOAD, ACTIVE)
  - IDLE: dout=0 and dout_oe=0. A synced cs_b falling edge goes to LOAD.
  - LOAD: one clk. Shift register <= {LEAD_ZEROS zeros, sample_data}, bit_cnt <= 0, dout_oe=1, then ACTIVE. dout is the shift register MSB, which is 0.
  - ACTIVE, SCLK rising edge k (k=0..15):
    - At k=2,3,4, din is shifted into addr_shift MSB first (ADD2, ADD1, ADD0).
    - bit_cnt increments.
  - ACTIVE, SCLK falling edge: shift register shifts left, zero fill. dout always equals shift register MSB, so the master's rising edge k sees bit 15-k: D11 at k=4, D0 at k=15.
  - ACTIVE, rising edge k=15:
    - frame_done pulses the following clk.
    - addr_rx <= addr_shift and req_ch <= addr_shift.
    - If cs_b is still low, go to LOAD (continuous mode: back-to-back frames with no CS gap). Otherwise wait in ACTIVE until cs_b rises, then go to IDLE with no abort.
  - Falling SCLK edges after k=15 and before the LOAD completes are ignored.
- Boundary conditions
  - cs_b rising with bit_cnt between 1 and 15: frame_abort pulses, state goes to IDLE, req_ch and addr_rx are unchanged, the partial address is discarded.
  - cs_b rising with bit_cnt=0: silent return to IDLE.
  - sclk edges while in IDLE are ignored.
  - A cs_b edge and an sclk edge in the same clk: the cs_b edge wins.
  - The first frame after reset returns channel 0, because req_ch resets to 0.
  - Reset asserted mid-frame returns every register to its reset value at once.
  - Address values 0..7 are all legal; there is no error condition.
- Latency
  - Samples are pipelined by one frame: each frame returns the channel addressed in the previous frame.
  - sample_data is captured once per frame, in LOAD, so later changes do not corrupt the frame in flight.
  - Pin-to-internal latency is SYNC_STAGES+1 clk. This bounds the maximum SCLK at clk/8.

Decomposition:
- Package adc_spi_pkg holds ADC_DATA_W=12, ADC_ADDR_W=3, ADC_FRAME_BITS=16, ADC_LEAD_ZEROS=4, and the state enum typedef (IDLE, LOAD, ACTIVE). The existing master is intended to import the same package.
- One natural sub-module: sync_edge_det. It contains the synchronizer plus rise/fall pulse outputs, is parameterized by SYNC_STAGES, and is instantiated three times.

Test Plan:
- Reset, then one frame with master ADD=5 and sample_data(ch0)=12'hA5C:
  - DOUT sequence seen by the master is 0000 1010 0101 1100.
  - addr_rx=5, req_ch=5, frame_done pulses once.
- Second frame with ADD=2 and sample_data(ch5)=12'h3F1: master reads 12'h3F1; then req_ch=2.
- Continuous mode, 3 frames back-to-back without raising cs_b, ADD=1,2,3 and sample_data=channel*12'h111:
  - Reads are 12'h000, 12'h111, 12'h222.
  - frame_done pulses 3 times.
- cs_b raised after 7 SCLK edges of a frame with ADD=6:
  - frame_abort pulses once; req_ch keeps its prior value; dout=0, dout_oe=0 within SYNC_STAGES+2 clk.
  - The next full frame returns the prior channel.
- Loopback with the existing SPI master at clk/8 SCLK, ADD=0, sample_data=12'h800: the master's data output equals 12'h800 after the second frame.
- Reset asserted at SCLK edge 10:
  - All outputs are 0 immediately; req_ch=0.
  - The following frame starts cleanly and returns the ch0 sample.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared constants and state type for the ADC SPI responder and the matching master.
package adc_spi_pkg;

    localparam int ADC_DATA_W      = 12;
    localparam int ADC_ADDR_W      = 3;
    localparam int ADC_FRAME_BITS  = 16;
    localparam int ADC_LEAD_ZEROS  = 4;
    localparam int ADC_SYNC_STAGES = 2;

    // Index of the first SCLK rising edge that carries an address bit (ADD2).
    localparam int ADC_ADDR_FIRST  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } adc_state_e;

    // True when rising edge number k carries one of the channel address bits.
    function automatic bit in_addr_window(input int unsigned k);
        return (k >= ADC_ADDR_FIRST) && (k < ADC_ADDR_FIRST + ADC_ADDR_W);
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between the pedal's ADC master and the responder.
interface adc_spi_responder_if;

    logic cs_b;
    logic sclk;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (
        output cs_b,
        output sclk,
        output din,
        input  dout,
        input  dout_oe
    );

    modport slave (
        input  cs_b,
        input  sclk,
        input  din,
        output dout,
        output dout_oe
    );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the synchronized level (one clk wide each).
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer and keep the previous synced value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating an 8-channel 12-bit serial ADC. Everything runs on clk;
// SPI pins are oversampled, so clk must be at least 8x SCLK.
//
// state  | meaning
// IDLE   | deselected, dout and dout_oe low, waiting for cs_b to fall
// LOAD   | one clk: capture sample_data for req_ch into the shift register
// ACTIVE | frame in progress; count SCLK rising edges, shift on falling edges
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int ADDR_W      = ADC_ADDR_W,
    parameter int FRAME_BITS  = ADC_FRAME_BITS,
    parameter int LEAD_ZEROS  = ADC_LEAD_ZEROS,
    parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    adc_spi_responder_if.slave spi,
    output logic [ADDR_W-1:0] req_ch,
    input  logic [DATA_W-1:0] sample_data,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [ADDR_W-1:0] addr_rx
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(FRAME_BITS - 1);
    // bit_cnt parks here once all rising edges of the frame have been seen.
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic din_lvl, din_rise, din_fall;

    adc_state_e              state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [ADDR_W-1:0]       addr_shift_q;
    logic [ADDR_W-1:0]       req_ch_q;
    logic [ADDR_W-1:0]       addr_rx_q;
    logic                    dout_oe_q;
    logic                    frame_done_q;
    logic                    frame_abort_q;

    // cs_b idles high, so its synchronizer resets high to avoid a false edge.
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi.cs_b),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi.sclk),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // din goes through the same depth as sclk so both are aligned at the edge.
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi.din),
        .level_o (din_lvl),
        .rise_o  (din_rise),
        .fall_o  (din_fall)
    );

    logic unused_sync_taps;
    assign unused_sync_taps = sclk_lvl ^ din_rise ^ din_fall;

    // Frame sequencer: cs_b edges take priority over any SCLK edge in the same clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            addr_shift_q  <= '0;
            req_ch_q      <= '0;
            addr_rx_q     <= '0;
            dout_oe_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    shift_q   <= '0;
                    dout_oe_q <= 1'b0;
                    bit_cnt_q <= '0;
                    if (cs_fall) begin
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    bit_cnt_q <= '0;
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        shift_q   <= '0;
                        dout_oe_q <= 1'b0;
                    end else begin
                        shift_q      <= {{LEAD_ZEROS{1'b0}}, sample_data};
                        addr_shift_q <= '0;
                        dout_oe_q    <= 1'b1;
                        state_q      <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (cs_rise) begin
                        // Deselect part-way through the bit stream is an abort;
                        // req_ch/addr_rx keep their last completed values.
                        if (bit_cnt_q != '0 && bit_cnt_q != CNT_FULL) begin
                            frame_abort_q <= 1'b1;
                        end
                        state_q   <= IDLE;
                        shift_q   <= '0;
                        dout_oe_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (sclk_rise && bit_cnt_q < CNT_FULL) begin
                        if (in_addr_window(32'(bit_cnt_q))) begin
                            addr_shift_q <= {addr_shift_q[ADDR_W-2:0], din_lvl};
                        end
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_EDGE) begin
                            frame_done_q <= 1'b1;
                            addr_rx_q    <= addr_shift_q;
                            req_ch_q     <= addr_shift_q;
                            // cs_b still low means back-to-back frames.
                            if (!cs_lvl) begin
                                state_q <= LOAD;
                            end
                        end
                    end else if (sclk_fall && bit_cnt_q != '0 && bit_cnt_q < CNT_FULL) begin
                        // Only falling edges that follow a rising edge of this
                        // frame advance the data; the first MSB is already out.
                        shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    shift_q   <= '0;
                    dout_oe_q <= 1'b0;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

    assign spi.dout    = shift_q[FRAME_BITS-1];
    assign spi.dout_oe = dout_oe_q;
    assign req_ch      = req_ch_q;
    assign addr_rx     = addr_rx_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI master at clk/8 SCLK and
// checks reads against a channel-lookup reference model.
module tb_adc_spi_responder;
    import adc_spi_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    adc_spi_responder_if spi ();

    logic [2:0]  req_ch;
    logic [2:0]  addr_rx;
    logic [11:0] sample_data;
    logic        frame_done;
    logic        frame_abort;

    logic [11:0] lut [8];
    assign sample_data = lut[req_ch];

    adc_spi_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi         (spi),
        .req_ch      (req_ch),
        .sample_data (sample_data),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .addr_rx     (addr_rx)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    typedef struct {
        logic [2:0]  addr;
        int          nbits;
        bit          keep_low;
        logic [15:0] exp_rd;
        logic [2:0]  exp_req;
        logic [2:0]  exp_rx;
        int          exp_done;
        int          exp_abort;
    } vec_t;

    vec_t vecs [9];

    // reference model state
    logic [2:0] m_req;
    logic [2:0] m_rx;

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One master frame of nbits SCLK periods; address bits go out on edges 2..4.
    task automatic spi_frame(input logic [2:0] addr, input int nbits, input bit keep_low,
                             output logic [15:0] rd);
        rd = '0;
        if (spi.cs_b) begin
            spi.cs_b = 1'b0;
            wclk(8);
        end
        for (int k = 0; k < nbits; k++) begin
            if (k >= 2 && k <= 4) spi.din = addr[4-k];
            else spi.din = 1'($urandom_range(0, 1));
            wclk(4);
            spi.sclk = 1'b1;
            rd = {rd[14:0], spi.dout};
            wclk(4);
            spi.sclk = 1'b0;
        end
        if (!keep_low) begin
            wclk(4);
            spi.cs_b = 1'b1;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] addr, input int nbits,
                             input bit keep_low, input logic [15:0] exp_rd,
                             input logic [2:0] exp_req, input logic [2:0] exp_rx,
                             input int exp_done, input int exp_abort);
        int d0;
        int a0;
        logic [15:0] rd;
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_frame(addr, nbits, keep_low, rd);
        if (!keep_low) begin
            wclk(4);
            chk({tag, ".oe_off"}, 32'(spi.dout_oe), 32'd0);
            chk({tag, ".dout_off"}, 32'(spi.dout), 32'd0);
            wclk(4);
        end
        if (nbits > 0) chk({tag, ".read"}, 32'(rd), 32'(exp_rd));
        chk({tag, ".req_ch"}, 32'(req_ch), 32'(exp_req));
        chk({tag, ".addr_rx"}, 32'(addr_rx), 32'(exp_rx));
        chk({tag, ".done"}, 32'(done_cnt - d0), 32'(exp_done));
        chk({tag, ".abort"}, 32'(abort_cnt - a0), 32'(exp_abort));
    endtask

    function automatic vec_t mk(input logic [2:0] a, input int nb, input bit kl,
                                input logic [15:0] rd, input logic [2:0] rq,
                                input logic [2:0] rx, input int dn, input int ab);
        vec_t v;
        v.addr = a; v.nbits = nb; v.keep_low = kl; v.exp_rd = rd;
        v.exp_req = rq; v.exp_rx = rx; v.exp_done = dn; v.exp_abort = ab;
        return v;
    endfunction

    initial begin
        logic [15:0] rd;
        logic [15:0] full;
        logic [15:0] exp_rd;
        int d0;
        int a0;

        lut[0] = 12'hA5C; lut[1] = 12'h111; lut[2] = 12'h222; lut[3] = 12'h333;
        lut[4] = 12'h444; lut[5] = 12'h3F1; lut[6] = 12'h666; lut[7] = 12'h777;

        // addr, nbits, keep_low, read, req_ch, addr_rx, done, abort
        vecs[0] = mk(3'd5, 16, 1'b0, 16'h0A5C, 3'd5, 3'd5, 1, 0);
        vecs[1] = mk(3'd2, 16, 1'b0, 16'h03F1, 3'd2, 3'd2, 1, 0);
        vecs[2] = mk(3'd1, 16, 1'b1, 16'h0222, 3'd1, 3'd1, 1, 0);
        vecs[3] = mk(3'd2, 16, 1'b1, 16'h0111, 3'd2, 3'd2, 1, 0);
        vecs[4] = mk(3'd3, 16, 1'b0, 16'h0222, 3'd3, 3'd3, 1, 0);
        vecs[5] = mk(3'd6,  7, 1'b0, 16'h0001, 3'd3, 3'd3, 0, 1);
        vecs[6] = mk(3'd0, 16, 1'b0, 16'h0333, 3'd0, 3'd0, 1, 0);
        vecs[7] = mk(3'd7,  0, 1'b0, 16'h0000, 3'd0, 3'd0, 0, 0);
        vecs[8] = mk(3'd7, 16, 1'b0, 16'h0A5C, 3'd7, 3'd7, 1, 0);

        reset_n  = 1'b0;
        spi.cs_b = 1'b1;
        spi.sclk = 1'b0;
        spi.din  = 1'b0;
        wclk(3);
        chk("rst.dout", 32'(spi.dout), 32'd0);
        chk("rst.oe", 32'(spi.dout_oe), 32'd0);
        chk("rst.req_ch", 32'(req_ch), 32'd0);
        chk("rst.addr_rx", 32'(addr_rx), 32'd0);
        chk("rst.done", 32'(frame_done), 32'd0);
        chk("rst.abort", 32'(frame_abort), 32'd0);
        reset_n = 1'b1;
        wclk(6);

        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].nbits, vecs[i].keep_low,
                      vecs[i].exp_rd, vecs[i].exp_req, vecs[i].exp_rx,
                      vecs[i].exp_done, vecs[i].exp_abort);
        end

        // SCLK toggling while deselected must be ignored.
        d0 = done_cnt;
        for (int i = 0; i < 20; i++) begin
            spi.din = 1'($urandom_range(0, 1));
            wclk(4); spi.sclk = 1'b1; wclk(4); spi.sclk = 1'b0;
        end
        wclk(4);
        chk("idle_sclk.oe", 32'(spi.dout_oe), 32'd0);
        chk("idle_sclk.req_ch", 32'(req_ch), 32'd7);
        chk("idle_sclk.done", 32'(done_cnt - d0), 32'd0);

        // cs_b rise in the same clk as the 16th SCLK rise: deselect wins.
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_frame(3'd4, 15, 1'b1, rd);
        wclk(4);
        spi.sclk = 1'b1;
        spi.cs_b = 1'b1;
        wclk(8);
        spi.sclk = 1'b0;
        wclk(8);
        chk("cs_sclk_tie.abort", 32'(abort_cnt - a0), 32'd1);
        chk("cs_sclk_tie.done", 32'(done_cnt - d0), 32'd0);
        chk("cs_sclk_tie.req_ch", 32'(req_ch), 32'd7);
        chk("cs_sclk_tie.addr_rx", 32'(addr_rx), 32'd7);

        // Reset in the middle of a frame, after 10 SCLK edges.
        spi_frame(3'd4, 10, 1'b1, rd);
        reset_n = 1'b0;
        #1;
        chk("midrst.dout", 32'(spi.dout), 32'd0);
        chk("midrst.oe", 32'(spi.dout_oe), 32'd0);
        chk("midrst.req_ch", 32'(req_ch), 32'd0);
        chk("midrst.addr_rx", 32'(addr_rx), 32'd0);
        chk("midrst.done", 32'(frame_done), 32'd0);
        chk("midrst.abort", 32'(frame_abort), 32'd0);
        spi.cs_b = 1'b1;
        wclk(3);
        reset_n = 1'b1;
        wclk(6);
        run_check("post_rst", 3'd3, 16, 1'b0, {4'h0, lut[0]}, 3'd3, 3'd3, 1, 0);

        // Randomized frames against the channel-lookup model.
        m_req = 3'd3;
        m_rx  = 3'd3;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] a;
            int nb;
            int mode;
            bit kl;
            if (spi.cs_b) lut[$urandom_range(0, 7)] = 12'($urandom);
            a    = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 7);
            if (mode == 0) nb = 0;
            else if (mode <= 2) nb = $urandom_range(1, 15);
            else nb = 16;
            kl   = (nb == 16) && (i != 39) && ($urandom_range(0, 1) == 1);
            full = {4'h0, lut[m_req]};
            exp_rd = (nb > 0) ? (full >> (16 - nb)) : 16'h0;
            if (nb == 16) begin
                m_req = a;
                m_rx  = a;
            end
            run_check($sformatf("rnd%0d", i), a, nb, kl, exp_rd, m_req, m_rx,
                      (nb == 16) ? 1 : 0, (nb > 0 && nb < 16) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
